// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus capture front end.
// Pairs camera bytes into RGB565 pixels tagged with x/y, emits frame and line
// markers, and flags lines whose byte count is wrong. Capture only starts and
// stops on frame boundaries, so the frame-buffer writer never sees a partial frame.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_VSYNC | after reset / skipped frame: wait for vertical sync to start
// IN_VSYNC   | inside vertical sync: capture_en sampled when sync ends
// ACTIVE     | capturing lines until the next vertical sync starts
module ov7670_pixel_capture #(
  parameter int IMAGE_WIDTH       = 640,
  parameter int IMAGE_HEIGHT      = 480,
  parameter int VSYNC_ACTIVE_HIGH = 1,
  parameter int COORD_W           = 10
) (
  input  logic               PixelClk,
  input  logic               nRST,
  input  logic               capture_en,
  input  logic               cam_vsync,
  input  logic               href,
  input  logic [7:0]         p_data,
  output logic [15:0]        pixel_data,
  output logic               pixel_valid,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start,
  output logic               line_end,
  output logic               frame_end,
  output logic               line_error,
  output logic [COORD_W-1:0] frame_lines
);

  localparam int LINE_BYTES = 2 * IMAGE_WIDTH;
  // One extra code above a full line marks "overrun" without wrapping.
  localparam int BYTE_W = $clog2(LINE_BYTES + 2);
  localparam logic [BYTE_W-1:0]  BYTES_FULL = BYTE_W'(LINE_BYTES);
  localparam logic [BYTE_W-1:0]  BYTES_OVER = BYTE_W'(LINE_BYTES + 1);
  localparam logic [COORD_W-1:0] HEIGHT_C   = COORD_W'(IMAGE_HEIGHT);
  localparam logic [COORD_W-1:0] LINES_MAX  = '1;
  localparam logic               VS_INV     = (VSYNC_ACTIVE_HIGH == 0);

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    IN_VSYNC   = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t              state;
  logic                vsync_q;
  logic                href_q;
  logic [7:0]          data_q;
  logic                vs_prev;
  logic                hact_prev;
  logic [7:0]          hi_byte;
  logic [BYTE_W-1:0]   byte_cnt;
  logic [COORD_W-1:0]  x_cnt;
  logic [COORD_W-1:0]  line_cnt;
  logic                start_armed;

  logic                vs;
  logic                hact;
  logic                vs_rise;
  logic                vs_fall;
  logic                line_close;
  logic                line_kept;
  logic [COORD_W-1:0]  lines_next;

  // Decode sync polarity and edges from the registered camera bus.
  // href is masked by vsync so a line can never overlap vertical sync;
  // vsync rising during a line therefore closes that line in the same cycle.
  always_comb begin
    vs         = vsync_q ^ VS_INV;
    hact       = href_q & ~vs;
    vs_rise    = vs & ~vs_prev;
    vs_fall    = ~vs & vs_prev;
    line_close = hact_prev & ~hact;
    line_kept  = (line_cnt < HEIGHT_C);
    lines_next = line_cnt;
    if (line_close && (line_cnt != LINES_MAX)) begin
      lines_next = line_cnt + 1'b1;
    end
  end

  // Register the camera bus once; sync reset parks vsync at its inactive level.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      vsync_q   <= VS_INV;
      href_q    <= 1'b0;
      data_q    <= 8'd0;
      vs_prev   <= 1'b0;
      hact_prev <= 1'b0;
    end else begin
      vsync_q   <= cam_vsync;
      href_q    <= href;
      data_q    <= p_data;
      vs_prev   <= vs;
      hact_prev <= hact;
    end
  end

  // Frame FSM, byte pairing, line bookkeeping and all registered outputs.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      state       <= WAIT_VSYNC;
      hi_byte     <= 8'd0;
      byte_cnt    <= '0;
      x_cnt       <= '0;
      line_cnt    <= '0;
      start_armed <= 1'b0;
      pixel_data  <= 16'd0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      line_error  <= 1'b0;
      frame_lines <= '0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      line_error  <= 1'b0;

      case (state)
        WAIT_VSYNC: begin
          if (vs) begin
            state <= IN_VSYNC;
          end
        end

        IN_VSYNC: begin
          if (vs_fall) begin
            byte_cnt <= '0;
            x_cnt    <= '0;
            line_cnt <= '0;
            if (capture_en) begin
              state       <= ACTIVE;
              start_armed <= 1'b1;
            end else begin
              state <= WAIT_VSYNC;
            end
          end
        end

        ACTIVE: begin
          if (hact) begin
            if (byte_cnt != BYTES_OVER) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
            // Overrun bytes and lines past the image height produce nothing.
            if ((byte_cnt < BYTES_FULL) && line_kept) begin
              if (!byte_cnt[0]) begin
                hi_byte <= data_q;
              end else begin
                pixel_data  <= {hi_byte, data_q};
                pixel_valid <= 1'b1;
                pixel_x     <= x_cnt;
                pixel_y     <= line_cnt;
                frame_start <= start_armed;
                start_armed <= 1'b0;
                x_cnt       <= x_cnt + 1'b1;
              end
            end
          end

          // A dangling half pixel is simply dropped by clearing the byte count.
          if (line_close) begin
            byte_cnt <= '0;
            x_cnt    <= '0;
            line_cnt <= lines_next;
            if (line_kept) begin
              line_end   <= 1'b1;
              line_error <= (byte_cnt != BYTES_FULL);
            end
          end

          if (vs_rise) begin
            frame_end   <= 1'b1;
            frame_lines <= lines_next;
            state       <= IN_VSYNC;
          end
        end

        default: begin
          state <= WAIT_VSYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Self-checking bench for ov7670_pixel_capture with a small image geometry.
module tb_ov7670_pixel_capture;

  localparam int W      = 8;
  localparam int H      = 6;
  localparam int GAP    = 6;
  localparam int VS_LEN = 10;
  localparam int BP     = 8;

  typedef struct packed {
    logic [15:0] data;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
  } pix_t;

  typedef struct packed {
    logic err;
    logic fe;
  } line_t;

  typedef struct packed {
    logic [9:0] lines;
    logic       le;
  } frame_t;

  logic        clk = 1'b0;
  logic        nRST;
  logic        capture_en;
  logic        cam_vsync;
  logic        href;
  logic [7:0]  p_data;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_start;
  logic        line_end;
  logic        frame_end;
  logic        line_error;
  logic [9:0]  frame_lines;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_first_cyc = 0;
  int plan[$];

  pix_t   act_pix[$];
  int     act_cyc[$];
  line_t  act_line[$];
  frame_t act_frame[$];
  string  orphans[$];
  pix_t   exp_pix[$];
  line_t  exp_line[$];
  frame_t exp_frame[$];

  ov7670_pixel_capture #(
    .IMAGE_WIDTH(W),
    .IMAGE_HEIGHT(H),
    .VSYNC_ACTIVE_HIGH(1),
    .COORD_W(10)
  ) dut (
    .PixelClk(clk),
    .nRST(nRST),
    .capture_en(capture_en),
    .cam_vsync(cam_vsync),
    .href(href),
    .p_data(p_data),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .frame_start(frame_start),
    .line_end(line_end),
    .frame_end(frame_end),
    .line_error(line_error),
    .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect output events away from the active edge.
  always @(negedge clk) begin
    if (pixel_valid) begin
      act_pix.push_back(pix_t'{pixel_data, pixel_x, pixel_y, frame_start});
      act_cyc.push_back(cyc);
    end else if (frame_start) begin
      orphans.push_back("frame_start without pixel_valid");
    end
    if (line_end) act_line.push_back(line_t'{line_error, frame_end});
    else if (line_error) orphans.push_back("line_error without line_end");
    if (frame_end) act_frame.push_back(frame_t'{frame_lines, line_end});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    cam_vsync = vs;
    href      = hr;
    p_data    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " pixel_valid"}, 32'(pixel_valid), 32'd0);
    chk({tag, " pixel_data"},  32'(pixel_data),  32'd0);
    chk({tag, " pixel_x"},     32'(pixel_x),     32'd0);
    chk({tag, " pixel_y"},     32'(pixel_y),     32'd0);
    chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, " line_end"},    32'(line_end),    32'd0);
    chk({tag, " frame_end"},   32'(frame_end),   32'd0);
    chk({tag, " line_error"},  32'(line_error),  32'd0);
    chk({tag, " frame_lines"}, 32'(frame_lines), 32'd0);
  endtask

  task automatic vsync_pulse(input logic href_hold);
    for (int i = 0; i < VS_LEN; i++) step(1'b1, href_hold, 8'($urandom));
    for (int i = 0; i < BP; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  // Drive one frame from 'plan' (bytes per line) and build the expected events,
  // then close it with a vsync pulse. rst_line/rst_byte place a 1-cycle reset.
  task automatic run_frame(input bit cap, input bit trunc, input bit idx,
                           input int rst_line, input int rst_byte);
    bit dead  = 1'b0;
    bit first = 1'b1;
    int nl    = plan.size();
    logic [7:0] b[$];
    for (int li = 0; li < nl; li++) begin
      int n = plan[li];
      bit last_trunc = trunc && (li == nl - 1);
      bit kept = cap && !dead && (li < H);
      int np = (n / 2 > W) ? W : n / 2;
      b.delete();
      for (int k = 0; k < n; k++) b.push_back(idx ? 8'(k) : 8'($urandom));
      for (int k = 0; k < n; k++) begin
        if (li == rst_line && k == rst_byte) begin
          nRST = 1'b0;
          step(1'b0, 1'b1, b[k]);
          check_zero("reset_mid_frame");
          nRST = 1'b1;
          dead = 1'b1;
        end else begin
          step(1'b0, 1'b1, b[k]);
          if (kept && li == 0 && k == 1) exp_first_cyc = cyc + 1;
        end
      end
      if (kept) begin
        for (int k = 0; k < np; k++) begin
          // A pixel survives a reset only if its second byte was processed before it.
          if (li != rst_line || (2 * k + 2 < rst_byte)) begin
            exp_pix.push_back(pix_t'{{b[2*k], b[2*k+1]}, 10'(k), 10'(li), first});
            first = 1'b0;
          end
        end
        if (li != rst_line) exp_line.push_back(line_t'{(n != 2 * W), last_trunc});
      end
      if (!last_trunc) begin
        for (int g = 0; g < GAP; g++) step(1'b0, 1'b0, 8'($urandom));
        if (kept && !dead && n >= 2 * W) chk("pixel_x_hold", 32'(pixel_x), 32'(W - 1));
      end
    end
    if (cap && !dead) exp_frame.push_back(frame_t'{10'(nl), trunc});
    vsync_pulse(trunc);
  endtask

  task automatic check_frame(input string name);
    int n;
    chk({name, " pixel_count"}, act_pix.size(), exp_pix.size());
    n = (act_pix.size() < exp_pix.size()) ? act_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s pix%0d data", name, i), 32'(act_pix[i].data), 32'(exp_pix[i].data));
      chk($sformatf("%s pix%0d x", name, i),    32'(act_pix[i].x),    32'(exp_pix[i].x));
      chk($sformatf("%s pix%0d y", name, i),    32'(act_pix[i].y),    32'(exp_pix[i].y));
      chk($sformatf("%s pix%0d fs", name, i),   32'(act_pix[i].fs),   32'(exp_pix[i].fs));
    end
    if (exp_pix.size() > 0 && act_cyc.size() > 0)
      chk({name, " first_pixel_latency"}, act_cyc[0], exp_first_cyc);
    chk({name, " line_end_count"}, act_line.size(), exp_line.size());
    n = (act_line.size() < exp_line.size()) ? act_line.size() : exp_line.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s line%0d error", name, i), 32'(act_line[i].err), 32'(exp_line[i].err));
      chk($sformatf("%s line%0d with_frame_end", name, i), 32'(act_line[i].fe), 32'(exp_line[i].fe));
    end
    chk({name, " frame_end_count"}, act_frame.size(), exp_frame.size());
    n = (act_frame.size() < exp_frame.size()) ? act_frame.size() : exp_frame.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s frame%0d lines", name, i), 32'(act_frame[i].lines), 32'(exp_frame[i].lines));
      chk($sformatf("%s frame%0d with_line_end", name, i), 32'(act_frame[i].le), 32'(exp_frame[i].le));
    end
    chk({name, " stray_pulses"}, orphans.size(), 0);
    act_pix.delete();
    act_cyc.delete();
    act_line.delete();
    act_frame.delete();
    orphans.delete();
    exp_pix.delete();
    exp_line.delete();
    exp_frame.delete();
  endtask

  initial begin
    nRST       = 1'b0;
    capture_en = 1'b1;
    cam_vsync  = 1'b0;
    href       = 1'b0;
    p_data     = 8'd0;

    // Reset with random bus activity.
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'($urandom), 8'($urandom));
    check_zero("reset");

    // Release reset in the middle of a line of a frame already running.
    for (int k = 0; k < 2 * W; k++) begin
      if (k == 5) nRST = 1'b1;
      step(1'b0, 1'b1, 8'(k));
    end
    for (int g = 0; g < GAP; g++) step(1'b0, 1'b0, 8'd0);
    plan = '{16, 16, 16};
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    check_frame("midstart");

    // Nominal frame, byte-index data, two lines beyond the image height.
    plan = '{16, 16, 16, 16, 16, 16, 16, 16};
    run_frame(1'b1, 1'b0, 1'b1, -1, -1);
    if (act_pix.size() >= 2) begin
      chk("nominal pixel0", 32'(act_pix[0].data), 32'h0001);
      chk("nominal pixel1", 32'(act_pix[1].data), 32'h0203);
    end else begin
      chk("nominal pixel_count_min", act_pix.size(), 2);
    end
    check_frame("nominal");

    // Malformed lines, last one cut by vsync; capture_en drops mid-frame.
    capture_en = 1'b0;
    plan = '{15, 16, 20, 14, 16, 9};
    run_frame(1'b1, 1'b1, 1'b0, -1, -1);
    check_frame("errors");

    // This frame was declined at its vsync fall; capture_en rises mid-frame.
    capture_en = 1'b1;
    plan = '{16, 16, 16, 16};
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    check_frame("skipped");

    // One-cycle reset on line 3, byte 9.
    plan = '{16, 16, 16, 16, 16, 16};
    run_frame(1'b1, 1'b0, 1'b0, 3, 9);
    check_frame("reset_abort");

    // Capture resumes after the vsync that followed the reset.
    plan = '{16, 16, 16, 16, 16, 16, 16};
    run_frame(1'b1, 1'b0, 1'b0, -1, -1);
    check_frame("resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
